sampler_tag_table: RTL
======================

Name: sampler_tag_table

Overview:
- 16-entry fully-associative table of sampled address tags with per-entry reference timestamps, in the lease-cache sampler.
- Sits directly upstream of the 16-to-4 tag match encoder. Compares each request tag against all entries and drives a registered 16-bit one-hot match vector to the encoder.
- Takes the encoder's 4-bit index back in the following cycle. On a hit it reports the reuse interval and frees the entry; on a miss it optionally inserts the tag.

Parameters:
- TAG_WIDTH, 26, width of the compared address tag
- TIME_WIDTH, 32, width of the request timestamp counter and the reuse interval
- (Entry count is fixed at 16, matching the 16-bit encoder input.)

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- req_i  in  1  request strobe; accepted every cycle, no backpressure
- tag_i  in  TAG_WIDTH  request tag
- sample_i  in  1  on a miss, insert tag_i if a slot is free
- flush_i  in  1  invalidate all entries
- match_bits_o  out  16  registered one-hot match vector, to the encoder
- match_valid_o  out  1  match_bits_o qualifies a request (stage 2 occupied)
- match_index_i  in  4  encoder index for match_bits_o, combinational in the same cycle
- rsp_valid_o  out  1  response strobe, one cycle per accepted request
- hit_o  out  1  response was a hit
- hit_index_o  out  4  entry that hit
- reuse_o  out  TIME_WIDTH  reuse interval on a hit, 0 on a miss
- insert_o  out  1  response miss was inserted
- drop_o  out  1  response miss with sample_i=1 but table full
- occupancy_o  out  5  valid entry count, 0..16

Behaviour:
- Reset (async): all valid bits 0, tags/timestamps don't-care, time counter 0, both pipeline stages empty, every output 0.
- Time counter: +1 per accepted req_i (req_i & ~flush_i), modulo 2^TIME_WIDTH. The request captures the pre-increment value as its timestamp.
- Stage 1 (cycle T): compare tag_i with every valid entry. Register the raw match vector, tag, timestamp and sample bit.
  - At T+1: match_bits_o and match_valid_o=1.
  - When stage 2 is empty: match_bits_o=0, match_valid_o=0.
- Stage 2 (cycle T+1):
  - hit = |match_bits_o; index = match_index_i.
  - Hit: clear valid[index] at the end of T+1.
  - Miss with sample=1 and a free slot: write tag/timestamp into the lowest-numbered invalid entry and set its valid bit.
  - Miss with table full: no write.
- Stage 2 outputs (registered, cycle T+2): rsp_valid_o, hit_o, hit_index_o (index on hit, else 0), reuse_o, insert_o, drop_o.
  - reuse_o = req_time - stored_time, modulo 2^TIME_WIDTH, i.e. wrap-safe subtraction.
- Latency: request to response is 2 cycles. Full throughput of 1 request per cycle.
- Back-to-back forwarding: request B in stage 1 while request A is in stage 2.
  - A hits entry k: B's match bit k is forced 0.
  - A inserts into slot s and tag_B == tag_A: B's match bit s is forced 1, and the other bits are unaffected. B's timestamp read at T+2 sees A's write.
- One-hot invariant: a tag never occupies two valid entries, so match_bits_o has at most one bit set.
- occupancy_o: registered. +1 on insert, -1 on hit invalidate, 0 on flush.
- Flush:
  - flush_i clears all valid bits at the clock edge and overrides any stage 2 insert or invalidate in that cycle.
  - A stage 1 request in that cycle is dropped: no stage 2 entry, no response, no counter increment.
  - A request already in stage 2 still produces its response.
- Reset asserted mid-operation: in-flight requests are lost with no response.

Test Plan:
- Reset, then req tag 0x5A at t=0 with sample_i=1 -> at T+2: rsp_valid_o=1, hit_o=0, insert_o=1, occupancy_o=1. Slot 0 is written.
- Same tag 0x5A again 10 requests later -> match_bits_o=0x0001 at T+1. Response: hit_o=1, hit_index_o=0, reuse_o=10, occupancy_o=0.
- Insert 16 distinct tags, then a 17th miss with sample_i=1 -> drop_o=1, insert_o=0, occupancy_o=16. Hits on tags 3 and 9 then free slots 3 and 9; the next insert lands in slot 3.
- Back-to-back identical tag 0x77 on two consecutive cycles, empty table -> first response insert_o=1; second response hit_o=1, hit_index_o=0, reuse_o=1.
- Timestamp wrap: preload the counter to 2^32-2, insert a tag, hit it 5 requests later -> reuse_o=5.
- flush_i coincident with a stage 2 insert and a new stage 1 request -> occupancy_o=0. The stage 2 response is still issued; the stage 1 request gets no response. The next access to the flushed tag misses.

Source files
------------

// File: rtl/sampler_tag_table.sv
// Lease-cache sampler tag table: 16 fully-associative tag/timestamp entries.
// Stage 1 compares and registers a one-hot match; stage 2 takes the encoder index back and responds.
module sampler_tag_table #(
   parameter int TAG_WIDTH  = 26,
   parameter int TIME_WIDTH = 32
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  req_i,
   input  logic [TAG_WIDTH-1:0]  tag_i,
   input  logic                  sample_i,
   input  logic                  flush_i,
   output logic [15:0]           match_bits_o,
   output logic                  match_valid_o,
   input  logic [3:0]            match_index_i,
   output logic                  rsp_valid_o,
   output logic                  hit_o,
   output logic [3:0]            hit_index_o,
   output logic [TIME_WIDTH-1:0] reuse_o,
   output logic                  insert_o,
   output logic                  drop_o,
   output logic [4:0]            occupancy_o
);

   logic [15:0]           valid_q;
   logic [TAG_WIDTH-1:0]  tag_mem  [16];
   logic [TIME_WIDTH-1:0] time_mem [16];
   logic [TIME_WIDTH-1:0] time_q;

   logic [TAG_WIDTH-1:0]  s2_tag;
   logic [TIME_WIDTH-1:0] s2_time;
   logic                  s2_sample;

   logic                  accept;
   logic                  s2_hit;
   logic                  s2_insert;
   logic                  s2_drop;
   logic                  has_free;
   logic [3:0]            free_idx;
   logic [TIME_WIDTH-1:0] reuse_d;
   logic [15:0]           raw_match;

   assign accept   = req_i & ~flush_i;
   assign s2_hit   = |match_bits_o;
   assign has_free = ~&valid_q;

   // Lowest-numbered invalid entry is the insertion slot.
   always_comb begin
      free_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = 4'(i);
      end
   end

   always_comb begin
      s2_insert = match_valid_o & ~s2_hit & s2_sample & has_free;
      s2_drop   = match_valid_o & ~s2_hit & s2_sample & ~has_free;
      reuse_d   = '0;
      if (s2_hit) reuse_d = s2_time - time_mem[match_index_i];
   end

   // Forward the stage 2 invalidate/insert so the request behind sees the updated table.
   always_comb begin
      raw_match = '0;
      for (int i = 0; i < 16; i++) begin
         raw_match[i] = valid_q[i] && (tag_mem[i] == tag_i);
      end
      if (s2_hit) raw_match[match_index_i] = 1'b0;
      if (s2_insert && (tag_i == s2_tag)) raw_match[free_idx] = 1'b1;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q     <= '0;
         occupancy_o <= '0;
         time_q      <= '0;
      end else begin
         if (accept) time_q <= time_q + 1'b1;
         if (flush_i) begin
            valid_q     <= '0;
            occupancy_o <= '0;
         end else begin
            if (s2_hit) begin
               valid_q[match_index_i] <= 1'b0;
               occupancy_o            <= occupancy_o - 5'd1;
            end
            if (s2_insert) begin
               valid_q[free_idx] <= 1'b1;
               occupancy_o       <= occupancy_o + 5'd1;
            end
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (s2_insert && !flush_i) begin
         tag_mem[free_idx]  <= s2_tag;
         time_mem[free_idx] <= s2_time;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         match_valid_o <= 1'b0;
         match_bits_o  <= '0;
         s2_tag        <= '0;
         s2_time       <= '0;
         s2_sample     <= 1'b0;
      end else begin
         match_valid_o <= accept;
         match_bits_o  <= accept ? raw_match : 16'd0;
         if (accept) begin
            s2_tag    <= tag_i;
            s2_time   <= time_q;
            s2_sample <= sample_i;
         end
      end
   end

   // Response reports the stage 2 decision; a coincident flush only affects the table.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         rsp_valid_o <= 1'b0;
         hit_o       <= 1'b0;
         hit_index_o <= '0;
         reuse_o     <= '0;
         insert_o    <= 1'b0;
         drop_o      <= 1'b0;
      end else begin
         rsp_valid_o <= match_valid_o;
         hit_o       <= s2_hit;
         hit_index_o <= s2_hit ? match_index_i : 4'd0;
         reuse_o     <= reuse_d;
         insert_o    <= s2_insert;
         drop_o      <= s2_drop;
      end
   end

endmodule
